// File: rtl/sdi_pos_scatter.sv
// sdi_pos_scatter: on a trigger, sweeps the SDI link DPRAM over a run-time
// cell x slot grid and scatters the leading slots of each cell into the X
// (even slot) and Y (odd slot) position BRAMs, then pulses done to start the
// downstream matrix calculation.
module sdi_pos_scatter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int BRAM_AW   = 9,
    parameter int MAX_CELLS = 30,
    parameter int CNT_W     = 5,
    parameter int RD_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 trig,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [CNT_W-1:0]     cell_count,
    input  logic [CNT_W-1:0]     slots_per_cell,
    input  logic [CNT_W-1:0]     fofb_slots,
    input  logic [MAX_CELLS-1:0] cell_mask,
    output logic                 ram_rd,
    output logic [ADDR_W-1:0]    ram_addr,
    input  logic [DATA_W-1:0]    ram_data,
    output logic                 x_wr,
    output logic                 y_wr,
    output logic [BRAM_AW-1:0]   x_addr,
    output logic [BRAM_AW-1:0]   y_addr,
    output logic [DATA_W-1:0]    x_data,
    output logic [DATA_W-1:0]    y_data,
    output logic [CNT_W-1:0]     cell_cnt,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                 state_reg, state_next;

    logic [CNT_W-1:0]       cells_reg;
    logic [CNT_W-1:0]       slots_reg;
    logic [CNT_W-1:0]       fofb_reg;
    logic [MAX_CELLS-1:0]   mask_reg;
    logic [CNT_W-1:0]       slot_reg;
    logic [CNT_W-1:0]       cell_reg;
    logic [ADDR_W-1:0]      addr_reg;
    logic [BRAM_AW-1:0]     xbase_reg, ybase_reg;
    logic [BRAM_AW-1:0]     xstep_reg, ystep_reg;
    logic [2:0]             drain_reg;
    logic                   overrun_reg;

    logic [CNT_W-1:0]       cells_clamp, fofb_clamp;
    logic [CNT_W:0]         xstep_wide, ystep_wide;
    logic                   zero_cfg;
    logic                   last_slot, last_cell;

    logic                   issue_wr, issue_odd;
    logic [BRAM_AW-1:0]     issue_addr;

    logic                   out_wr, out_odd;
    logic [BRAM_AW-1:0]     out_addr;

    // Clamp the incoming configuration and derive per-cell BRAM strides
    always_comb begin
        cells_clamp = cell_count;
        if (int'(cell_count) > MAX_CELLS)
            cells_clamp = CNT_W'(MAX_CELLS);
        fofb_clamp = (fofb_slots > slots_per_cell) ? slots_per_cell : fofb_slots;
        xstep_wide = ({1'b0, fofb_clamp} + (CNT_W+1)'(1)) >> 1;
        ystep_wide = {1'b0, fofb_clamp} >> 1;
        zero_cfg   = (cell_count == '0) || (slots_per_cell == '0);
        last_slot  = (slot_reg == slots_reg - CNT_W'(1));
        last_cell  = (cell_reg == cells_reg - CNT_W'(1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic: a trig is only accepted from IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (trig) state_next = zero_cfg ? DONE : READ;
            READ:    if (last_slot && last_cell) state_next = DRAIN;
            DRAIN:   if (drain_reg == 3'(RD_LAT - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Configuration latch, read address and slot/cell counters
    always_ff @(posedge clk) begin
        if (reset) begin
            cells_reg <= '0;
            slots_reg <= '0;
            fofb_reg  <= '0;
            mask_reg  <= '0;
            slot_reg  <= '0;
            cell_reg  <= '0;
            addr_reg  <= '0;
            xbase_reg <= '0;
            ybase_reg <= '0;
            xstep_reg <= '0;
            ystep_reg <= '0;
            drain_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (trig) begin
                        cells_reg <= cells_clamp;
                        slots_reg <= slots_per_cell;
                        fofb_reg  <= fofb_clamp;
                        mask_reg  <= cell_mask;
                        slot_reg  <= '0;
                        cell_reg  <= '0;
                        addr_reg  <= base_addr;
                        xbase_reg <= '0;
                        ybase_reg <= '0;
                        xstep_reg <= BRAM_AW'(xstep_wide);
                        ystep_reg <= BRAM_AW'(ystep_wide);
                        drain_reg <= '0;
                    end
                end
                READ: begin
                    addr_reg <= addr_reg + ADDR_W'(1);
                    if (last_slot) begin
                        slot_reg <= '0;
                        if (!last_cell) begin
                            cell_reg  <= cell_reg + CNT_W'(1);
                            xbase_reg <= xbase_reg + xstep_reg;
                            ybase_reg <= ybase_reg + ystep_reg;
                        end
                    end else begin
                        slot_reg <= slot_reg + CNT_W'(1);
                    end
                end
                DRAIN:   drain_reg <= drain_reg + 3'd1;
                default: ;
            endcase
        end
    end

    // Sticky overrun: set by a trig that arrives while busy, cleared on accept
    always_ff @(posedge clk) begin
        if (reset)
            overrun_reg <= 1'b0;
        else if (trig)
            overrun_reg <= (state_reg != IDLE);
    end

    // Tag of the word being requested this cycle; masked cells keep their address slot
    always_comb begin
        issue_wr   = (state_reg == READ) && (slot_reg < fofb_reg) && mask_reg[cell_reg];
        issue_odd  = slot_reg[0];
        issue_addr = (slot_reg[0] ? ybase_reg : xbase_reg) + BRAM_AW'(slot_reg >> 1);
    end

    // Tag delay line matching the DPRAM read latency
    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
            logic               tag_wr_reg;
            logic               tag_odd_reg;
            logic [BRAM_AW-1:0] tag_addr_reg;
            if (gi == 0) begin : g_head
                // First stage captures the tag issued with ram_rd
                always_ff @(posedge clk) begin
                    if (reset) begin
                        tag_wr_reg   <= 1'b0;
                        tag_odd_reg  <= 1'b0;
                        tag_addr_reg <= '0;
                    end else begin
                        tag_wr_reg   <= issue_wr;
                        tag_odd_reg  <= issue_odd;
                        tag_addr_reg <= issue_addr;
                    end
                end
            end else begin : g_tail
                // Later stages shift the tag one step further
                always_ff @(posedge clk) begin
                    if (reset) begin
                        tag_wr_reg   <= 1'b0;
                        tag_odd_reg  <= 1'b0;
                        tag_addr_reg <= '0;
                    end else begin
                        tag_wr_reg   <= g_pipe[gi-1].tag_wr_reg;
                        tag_odd_reg  <= g_pipe[gi-1].tag_odd_reg;
                        tag_addr_reg <= g_pipe[gi-1].tag_addr_reg;
                    end
                end
            end
        end
    endgenerate

    // Steer the returning word to X or Y; idle outputs are held at zero
    always_comb begin
        out_wr   = g_pipe[RD_LAT-1].tag_wr_reg;
        out_odd  = g_pipe[RD_LAT-1].tag_odd_reg;
        out_addr = g_pipe[RD_LAT-1].tag_addr_reg;
        x_wr     = out_wr && !out_odd;
        y_wr     = out_wr && out_odd;
        x_addr   = x_wr ? out_addr : '0;
        y_addr   = y_wr ? out_addr : '0;
        x_data   = x_wr ? ram_data : '0;
        y_data   = y_wr ? ram_data : '0;
        ram_rd   = (state_reg == READ);
        ram_addr = ram_rd ? addr_reg : '0;
        cell_cnt = cell_reg;
        busy     = (state_reg != IDLE);
        done     = (state_reg == DONE);
        overrun  = overrun_reg;
    end

endmodule

// File: tb/tb_sdi_pos_scatter.sv
// Directed bench for sdi_pos_scatter with a behavioural DPRAM of latency RD_LAT.
module tb_sdi_pos_scatter;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int BRAM_AW   = 9;
    localparam int MAX_CELLS = 30;
    localparam int CNT_W     = 5;
    localparam int RD_LAT    = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 trig;
    logic [ADDR_W-1:0]    base_addr;
    logic [CNT_W-1:0]     cell_count;
    logic [CNT_W-1:0]     slots_per_cell;
    logic [CNT_W-1:0]     fofb_slots;
    logic [MAX_CELLS-1:0] cell_mask;
    logic                 ram_rd;
    logic [ADDR_W-1:0]    ram_addr;
    logic [DATA_W-1:0]    ram_data;
    logic                 x_wr, y_wr;
    logic [BRAM_AW-1:0]   x_addr, y_addr;
    logic [DATA_W-1:0]    x_data, y_data;
    logic [CNT_W-1:0]     cell_cnt;
    logic                 busy, done, overrun;

    int checks = 0;
    int errors = 0;

    // Capture results of one sweep
    logic [ADDR_W-1:0]  rd_q[$];
    logic [CNT_W-1:0]   cell_q[$];
    logic [BRAM_AW-1:0] xa_q[$], ya_q[$];
    logic [DATA_W-1:0]  xd_q[$], yd_q[$];
    int first_rd, first_x, last_rd, done_cyc;
    logic busy0, ov0;

    sdi_pos_scatter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BRAM_AW(BRAM_AW),
        .MAX_CELLS(MAX_CELLS), .CNT_W(CNT_W), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .reset(reset), .trig(trig), .base_addr(base_addr),
        .cell_count(cell_count), .slots_per_cell(slots_per_cell),
        .fofb_slots(fofb_slots), .cell_mask(cell_mask),
        .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_data(ram_data),
        .x_wr(x_wr), .y_wr(y_wr), .x_addr(x_addr), .y_addr(y_addr),
        .x_data(x_data), .y_data(y_data), .cell_cnt(cell_cnt),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
        return 32'h5A00_0000 | {22'h0, a};
    endfunction

    // DPRAM model: contents are word_of(address), RD_LAT clocks of latency
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= ram_rd ? word_of(ram_addr) : 32'hBAD0_0000;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_data = rd_pipe[RD_LAT-1];

    task automatic start(input logic [ADDR_W-1:0] b, input int cells, input int slots,
                         input int fofb, input logic [MAX_CELLS-1:0] m);
        @(negedge clk);
        base_addr      = b;
        cell_count     = CNT_W'(cells);
        slots_per_cell = CNT_W'(slots);
        fofb_slots     = CNT_W'(fofb);
        cell_mask      = m;
        trig           = 1'b1;
        @(negedge clk);
    endtask

    // Sample each cycle after the accepting edge; cycle 0 is the first after trig
    task automatic capture(input int budget, input int inject, input int stop_at);
        int cyc;
        bit fin;
        rd_q.delete(); cell_q.delete();
        xa_q.delete(); ya_q.delete(); xd_q.delete(); yd_q.delete();
        first_rd = -1; first_x = -1; last_rd = -1; done_cyc = -1;
        cyc = 0; fin = 0;
        while (!fin) begin
            trig = (cyc == inject);
            if (cyc == inject) base_addr = base_addr ^ 10'h2AA;
            if (cyc == 0) begin busy0 = busy; ov0 = overrun; end
            if (ram_rd) begin
                rd_q.push_back(ram_addr);
                cell_q.push_back(cell_cnt);
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
            end
            if (x_wr) begin
                xa_q.push_back(x_addr); xd_q.push_back(x_data);
                if (first_x < 0) first_x = cyc;
            end
            if (y_wr) begin
                ya_q.push_back(y_addr); yd_q.push_back(y_data);
            end
            if (done) begin
                done_cyc = cyc; fin = 1;
            end else if (cyc == stop_at || cyc >= budget) begin
                fin = 1;
            end else begin
                cyc++;
                @(negedge clk);
            end
        end
        if (stop_at < 0) begin
            checks++;
            if (done_cyc < 0) begin
                $display("FAIL sweep_timeout: done not seen within %0d cycles, required a done pulse", budget);
                errors++;
            end
        end
        $display("sweep base=%0d cells=%0d slots=%0d fofb=%0d reads=%0d xw=%0d yw=%0d done_cyc=%0d",
                 base_addr, cell_count, slots_per_cell, fofb_slots, rd_q.size(),
                 xa_q.size(), ya_q.size(), done_cyc);
    endtask

    task automatic test_reset;
        reset = 1'b1; trig = 1'b0; base_addr = '0; cell_count = '0;
        slots_per_cell = '0; fofb_slots = '0; cell_mask = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); errors++; end
        checks++; if (done !== 1'b0) begin $display("FAIL reset_done: got %b want 0", done); errors++; end
        checks++; if (ram_rd !== 1'b0) begin $display("FAIL reset_ram_rd: got %b want 0", ram_rd); errors++; end
        checks++; if (overrun !== 1'b0) begin $display("FAIL reset_overrun: got %b want 0", overrun); errors++; end
        checks++;
        if ({ram_addr, x_wr, y_wr, x_addr, y_addr, x_data, y_data, cell_cnt} !== '0) begin
            $display("FAIL reset_outputs: got %h want 0",
                     {ram_addr, x_wr, y_wr, x_addr, y_addr, x_data, y_data, cell_cnt});
            errors++;
        end
        reset = 1'b0;
        @(negedge clk);
        $display("reset released");
    endtask

    task automatic test_nominal;
        logic [ADDR_W-1:0] src;
        start(10'd0, 2, 26, 12, {MAX_CELLS{1'b1}});
        capture(200, -1, -1);
        checks++; if (rd_q.size() != 52) begin $display("FAIL nom_reads: got %0d want 52", rd_q.size()); errors++; end
        if (rd_q.size() == 52)
            for (int i = 0; i < 52; i++) begin
                checks++;
                if (rd_q[i] !== ADDR_W'(i)) begin $display("FAIL nom_rd_addr[%0d]: got %0d want %0d", i, rd_q[i], i); errors++; end
            end
        checks++; if (first_rd != 0) begin $display("FAIL nom_first_rd: got %0d want 0", first_rd); errors++; end
        checks++; if (first_x != RD_LAT) begin $display("FAIL nom_first_x: got %0d want %0d", first_x, RD_LAT); errors++; end
        checks++; if (done_cyc != 54) begin $display("FAIL nom_done_cyc: got %0d want 54", done_cyc); errors++; end
        checks++; if (done_cyc - last_rd != RD_LAT + 1) begin $display("FAIL nom_done_lat: got %0d want %0d", done_cyc - last_rd, RD_LAT + 1); errors++; end
        if (cell_q.size() == 52) begin
            checks++; if (cell_q[25] !== 5'd0) begin $display("FAIL nom_cell25: got %0d want 0", cell_q[25]); errors++; end
            checks++; if (cell_q[26] !== 5'd1) begin $display("FAIL nom_cell26: got %0d want 1", cell_q[26]); errors++; end
        end
        checks++; if (xa_q.size() != 12) begin $display("FAIL nom_xw_count: got %0d want 12", xa_q.size()); errors++; end
        checks++; if (ya_q.size() != 12) begin $display("FAIL nom_yw_count: got %0d want 12", ya_q.size()); errors++; end
        if (xa_q.size() == 12 && ya_q.size() == 12)
            for (int i = 0; i < 12; i++) begin
                src = ADDR_W'((i < 6) ? 2*i : 26 + 2*(i-6));
                checks++;
                if (xa_q[i] !== BRAM_AW'(i) || xd_q[i] !== word_of(src)) begin
                    $display("FAIL nom_x[%0d]: got addr %0d data %h want addr %0d data %h", i, xa_q[i], xd_q[i], i, word_of(src)); errors++;
                end
                src = src + 10'd1;
                checks++;
                if (ya_q[i] !== BRAM_AW'(i) || yd_q[i] !== word_of(src)) begin
                    $display("FAIL nom_y[%0d]: got addr %0d data %h want addr %0d data %h", i, ya_q[i], yd_q[i], i, word_of(src)); errors++;
                end
            end
        @(negedge clk);
        checks++; if ({done, busy} !== 2'b00) begin $display("FAIL nom_after_done: got done/busy %b want 00", {done, busy}); errors++; end
    endtask

    task automatic test_mask;
        start(10'd0, 2, 26, 12, 30'b10);
        capture(200, -1, -1);
        checks++; if (first_x != 28) begin $display("FAIL mask_first_x: got %0d want 28", first_x); errors++; end
        checks++; if (xa_q.size() != 6 || ya_q.size() != 6) begin $display("FAIL mask_counts: got x %0d y %0d want 6 6", xa_q.size(), ya_q.size()); errors++; end
        if (xa_q.size() == 6 && ya_q.size() == 6)
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (xa_q[i] !== BRAM_AW'(6 + i) || xd_q[i] !== word_of(ADDR_W'(26 + 2*i))) begin
                    $display("FAIL mask_x[%0d]: got addr %0d data %h want addr %0d", i, xa_q[i], xd_q[i], 6 + i); errors++;
                end
                checks++;
                if (ya_q[i] !== BRAM_AW'(6 + i) || yd_q[i] !== word_of(ADDR_W'(27 + 2*i))) begin
                    $display("FAIL mask_y[%0d]: got addr %0d data %h want addr %0d", i, ya_q[i], yd_q[i], 6 + i); errors++;
                end
            end
        @(negedge clk);
    endtask

    task automatic test_clamp;
        // fofb larger than slots
        start(10'd0, 1, 4, 5, {MAX_CELLS{1'b1}});
        capture(100, -1, -1);
        checks++; if (rd_q.size() != 4) begin $display("FAIL clamp_reads: got %0d want 4", rd_q.size()); errors++; end
        checks++; if (done_cyc != 6) begin $display("FAIL clamp_done_cyc: got %0d want 6", done_cyc); errors++; end
        checks++;
        if (xa_q.size() != 2 || ya_q.size() != 2) begin
            $display("FAIL clamp_counts: got x %0d y %0d want 2 2", xa_q.size(), ya_q.size()); errors++;
        end else if ({xa_q[0], xa_q[1], ya_q[0], ya_q[1]} !== {9'd0, 9'd1, 9'd0, 9'd1} ||
                     {xd_q[1], yd_q[1]} !== {word_of(10'd2), word_of(10'd3)}) begin
            $display("FAIL clamp_xy: got x %0d,%0d y %0d,%0d want 0,1 0,1", xa_q[0], xa_q[1], ya_q[0], ya_q[1]); errors++;
        end
        @(negedge clk);
        // cell_count above MAX_CELLS, one forwarded slot per cell
        start(10'd0, 31, 1, 3, {MAX_CELLS{1'b1}});
        capture(200, -1, -1);
        checks++; if (rd_q.size() != 30) begin $display("FAIL clampc_reads: got %0d want 30", rd_q.size()); errors++; end
        checks++; if (ya_q.size() != 0) begin $display("FAIL clampc_yw: got %0d want 0", ya_q.size()); errors++; end
        checks++;
        if (xa_q.size() != 30) begin
            $display("FAIL clampc_xw: got %0d want 30", xa_q.size()); errors++;
        end else if (xa_q[29] !== 9'd29 || xd_q[29] !== word_of(10'd29)) begin
            $display("FAIL clampc_x29: got addr %0d data %h want addr 29", xa_q[29], xd_q[29]); errors++;
        end
        if (cell_q.size() == 30) begin
            checks++; if (cell_q[29] !== 5'd29) begin $display("FAIL clampc_cell: got %0d want 29", cell_q[29]); errors++; end
        end
        @(negedge clk);
    endtask

    task automatic test_zero;
        start(10'd0, 0, 26, 12, {MAX_CELLS{1'b1}});
        capture(20, -1, -1);
        checks++; if (done_cyc != 0) begin $display("FAIL zero_cells_done: got %0d want 0", done_cyc); errors++; end
        checks++; if (rd_q.size() != 0) begin $display("FAIL zero_cells_reads: got %0d want 0", rd_q.size()); errors++; end
        checks++; if (busy0 !== 1'b1) begin $display("FAIL zero_busy_in_done: got %b want 1", busy0); errors++; end
        @(negedge clk);
        start(10'd0, 3, 0, 0, {MAX_CELLS{1'b1}});
        capture(20, -1, -1);
        checks++; if (done_cyc != 0 || rd_q.size() != 0) begin $display("FAIL zero_slots: got done %0d reads %0d want 0 0", done_cyc, rd_q.size()); errors++; end
        @(negedge clk);
    endtask

    task automatic test_wrap;
        start(10'd1020, 1, 8, 8, {MAX_CELLS{1'b1}});
        capture(100, -1, -1);
        checks++; if (rd_q.size() != 8) begin $display("FAIL wrap_reads: got %0d want 8", rd_q.size()); errors++; end
        if (rd_q.size() == 8)
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (rd_q[i] !== ADDR_W'((1020 + i) % 1024)) begin $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, rd_q[i], (1020 + i) % 1024); errors++; end
            end
        checks++;
        if (xd_q.size() != 4) begin
            $display("FAIL wrap_xw: got %0d want 4", xd_q.size()); errors++;
        end else if (xd_q[2] !== word_of(10'd0) || xa_q[2] !== 9'd2) begin
            $display("FAIL wrap_x2: got addr %0d data %h want addr 2 data %h", xa_q[2], xd_q[2], word_of(10'd0)); errors++;
        end
        @(negedge clk);
    endtask

    task automatic test_overrun;
        // trig mid-sweep is ignored but flagged
        start(10'd100, 2, 26, 12, {MAX_CELLS{1'b1}});
        capture(200, 5, -1);
        checks++; if (ov0 !== 1'b0) begin $display("FAIL ovr_cleared_on_accept: got %b want 0", ov0); errors++; end
        checks++; if (rd_q.size() != 52) begin $display("FAIL ovr_reads: got %0d want 52", rd_q.size()); errors++; end
        checks++; if (rd_q.size() == 52 && rd_q[51] !== 10'd151) begin $display("FAIL ovr_last_addr: got %0d want 151", rd_q[51]); errors++; end
        checks++; if (xa_q.size() != 12) begin $display("FAIL ovr_xw: got %0d want 12", xa_q.size()); errors++; end
        checks++; if (overrun !== 1'b1) begin $display("FAIL ovr_set: got %b want 1", overrun); errors++; end
        @(negedge clk);
        checks++; if (overrun !== 1'b1) begin $display("FAIL ovr_sticky: got %b want 1", overrun); errors++; end
        // next accepted trig clears, then a trig on the done cycle is ignored
        start(10'd0, 1, 2, 2, {MAX_CELLS{1'b1}});
        capture(50, 4, -1);
        checks++; if (ov0 !== 1'b0) begin $display("FAIL ovr_clear_next_trig: got %b want 0", ov0); errors++; end
        checks++; if (done_cyc != 4) begin $display("FAIL ovr_done_cyc: got %0d want 4", done_cyc); errors++; end
        @(negedge clk);
        trig = 1'b0;
        checks++;
        if ({overrun, busy, ram_rd} !== 3'b100) begin
            $display("FAIL ovr_done_trig: got overrun/busy/rd %b want 100", {overrun, busy, ram_rd}); errors++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int bad;
        start(10'd0, 2, 26, 12, {MAX_CELLS{1'b1}});
        capture(200, 3, 10);
        checks++; if (rd_q.size() != 11) begin $display("FAIL rstm_reads: got %0d want 11", rd_q.size()); errors++; end
        checks++; if (overrun !== 1'b1) begin $display("FAIL rstm_overrun_pre: got %b want 1", overrun); errors++; end
        reset = 1'b1;
        trig = 1'b0;
        @(negedge clk);
        checks++;
        if ({ram_rd, ram_addr, x_wr, y_wr, x_addr, y_addr, x_data, y_data, cell_cnt, busy, done, overrun} !== '0) begin
            $display("FAIL rstm_outputs: got rd %b addr %0d xw %b yw %b cell %0d busy %b done %b ovr %b want all 0",
                     ram_rd, ram_addr, x_wr, y_wr, cell_cnt, busy, done, overrun); errors++;
        end
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (x_wr || y_wr || ram_rd || busy) bad++;
        end
        checks++; if (bad != 0) begin $display("FAIL rstm_quiet: got %0d active cycles want 0", bad); errors++; end
        $display("reset mid-sweep at read 10");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_mask();
        test_clamp();
        test_zero();
        test_wrap();
        test_overrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdi_pos_scatter.md
Name: sdi_pos_scatter

Overview:
- Parametrised successor of the fixed-geometry SDI position reader.
- On each fast-feedback trigger, sweeps the SDI DPRAM (port B) over a run-time-configurable cell × slot grid.
- Steers even slots to the X position BRAM and odd slots to the Y position BRAM, with per-cell masking.
- Pulses a start trigger for the downstream matrix calculation. Sits between the SDI link RAM and the FOFB matrix multiplier.

Parameters:
- ADDR_W, 10, SDI DPRAM address width.
- DATA_W, 32, position word width.
- BRAM_AW, 9, X/Y BRAM address width.
- MAX_CELLS, 30, number of bits in cell_mask; cell_count is capped at this value.
- CNT_W, 5, width of the cell/slot configuration and counter fields.
- RD_LAT, 2, DPRAM read latency in clocks (range 1..4).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- trig  in  1  start pulse, one clk wide
- base_addr  in  ADDR_W  first SDI address to read
- cell_count  in  CNT_W  number of cells to sweep
- slots_per_cell  in  CNT_W  SDI words per cell (e.g. 26)
- fofb_slots  in  CNT_W  leading slots per cell forwarded to the BRAMs (e.g. 12)
- cell_mask  in  MAX_CELLS  bit n=1 enables BRAM writes for cell n
- ram_rd  out  1  DPRAM read enable
- ram_addr  out  ADDR_W  DPRAM read address
- ram_data  in  DATA_W  DPRAM read data, valid RD_LAT clocks after ram_rd
- x_wr, y_wr  out  1  BRAM write enables
- x_addr, y_addr  out  BRAM_AW  BRAM write addresses
- x_data, y_data  out  DATA_W  BRAM write data
- cell_cnt  out  CNT_W  cell currently being read
- busy  out  1  sweep in progress
- done  out  1  one-clk pulse; sweep complete (DspMatrixCalStartTrig)
- overrun  out  1  sticky flag: trig arrived while busy

Behaviour:
- Reset values: all outputs 0. FSM = IDLE.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - trig latches base_addr, cell_count, slots_per_cell, fofb_slots and cell_mask, then clears overrun.
  - Enter READ. If cell_count == 0 or slots_per_cell == 0, enter DONE instead; no reads are issued.
- Configuration clamping (applied at latch time):
  - cell_count > MAX_CELLS is clamped to MAX_CELLS.
  - fofb_slots > slots_per_cell is clamped to slots_per_cell.
- READ:
  - ram_rd = 1 every cycle.
  - ram_addr starts at base_addr and increments by 1 per cycle, wrapping mod 2^ADDR_W.
  - Slot counter runs 0..slots_per_cell-1. On wrap, cell_cnt increments.
  - After cell_count*slots_per_cell reads, enter DRAIN.
- DRAIN: hold for RD_LAT cycles, then enter DONE.
- DONE: done = 1 for one cycle, then IDLE. busy = 1 in READ, DRAIN and DONE.
- Write pipeline:
  - The tag (slot, cell, masked) travels RD_LAT stages alongside ram_rd.
  - A returning word is forwarded when slot < fofb_slots AND cell_mask[cell] = 1.
  - Even slot: x_wr = 1, x_data = ram_data. Odd slot: y_wr = 1, y_data = ram_data.
- BRAM addresses:
  - x_addr = cell*ceil(fofb_slots/2) + slot/2.
  - y_addr = cell*floor(fofb_slots/2) + slot/2.
  - Masked cells suppress the write but still occupy their address range, so BRAM layout is fixed.
  - Addresses wrap mod 2^BRAM_AW.
- trig while busy:
  - Ignored; the sweep continues unaffected and overrun is set to 1.
  - overrun is cleared only by reset or by the next accepted trig.
- Simultaneous done and trig: the DONE cycle counts as busy, so the trig is ignored and overrun is set.
- reset mid-sweep:
  - Next cycle, all outputs are 0 and the FSM is in IDLE.
  - In-flight pipeline tags are flushed; no writes follow the reset.
- Latency:
  - First x_wr occurs RD_LAT clocks after the first ram_rd.
  - done occurs exactly RD_LAT+1 clocks after the last ram_rd.

Test Plan:
- Nominal sweep:
  - Setup: RD_LAT=2, base=0, cells=2, slots=26, fofb=12, mask all ones.
  - Expected: 52 reads (addr 0..51); 12 x_wr at x_addr 0..11 carrying words 0,2,…,10 and 26,…,36; 12 y_wr at y_addr 0..11.
  - Expected: done pulses 3 clk after ram_addr=51.
- Cell masking:
  - Setup: mask=0b10, cells=2.
  - Expected: no writes while cell 0 is read; cell 1 writes land at x_addr 6..11 and y_addr 6..11.
- Odd fofb and clamping:
  - Setup: fofb=5, slots=4, cells=1.
  - Expected: fofb clamps to 4; x_addr 0,1 and y_addr 0,1; 4 reads.
- Zero config: cell_count=0 -> done one cycle after trig entering IDLE; ram_rd is never asserted.
- Address wrap: base=1020, cells=1, slots=8 -> ram_addr sequence 1020..1023, 0..3.
- Overrun and reset:
  - Step 1: trig mid-sweep -> overrun=1 and the sweep completes unchanged.
  - Step 2: reset at read 10 -> no writes after the reset, all outputs 0.
  - Step 3: next trig -> overrun=0.
